// File: rtl/uart_rx_oversampled_if.sv
// Signal bundle between the UART receiver and its line/consumer side.
// done is a single-clk strobe; data_out and both error flags are valid on it and hold until the next one.
interface uart_rx_oversampled_if #(
  parameter int data_width = 8
);
  logic                  rx_en;
  logic                  parity_en;
  logic                  odd_or_even_parity;
  logic                  rx;
  logic                  busy;
  logic                  done;
  logic                  framing_error;
  logic                  parity_error;
  logic [data_width-1:0] data_out;
  logic [2:0]            state_dbg;

  modport master (
    output rx_en, parity_en, odd_or_even_parity, rx,
    input  busy, done, framing_error, parity_error, data_out, state_dbg
  );

  modport slave (
    input  rx_en, parity_en, odd_or_even_parity, rx,
    output busy, done, framing_error, parity_error, data_out, state_dbg
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver with OVS-times oversampling, 3-sample mid-bit majority vote,
// optional parity and stop-bit checking; one done strobe per completed frame.
module uart_rx_oversampled #(
  parameter int sys_clk    = 50_000_000,
  parameter int baud_rate  = 9600,
  parameter int data_width = 8,
  parameter int OVS        = 16
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_oversampled_if.slave bus
);

  localparam int DIV  = sys_clk / (baud_rate * OVS);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(OVS);
  localparam int IW   = $clog2(data_width + 1);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
  localparam logic [TW-1:0]   T_A      = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]   T_B      = TW'(OVS / 2);
  localparam logic [TW-1:0]   T_C      = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0]   T_END    = TW'(OVS - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [DIVW-1:0]       div_q, div_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [data_width-1:0] sh_q, sh_d;
  logic                  s_a_q, s_a_d, s_b_q, s_b_d;
  logic                  pend_q, pend_d;
  logic                  par_en_q, par_en_d, even_q, even_d;
  logic                  done_q, done_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  fe_q, fe_d, pe_q, pe_d;

  logic tick, at_a, at_b, at_c, at_end, maj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The divider sits at zero in IDLE, so the first START clk is tick 0 of the start bit.
  assign tick   = (div_q == '0);
  assign at_a   = tick && (tcnt_q == T_A);
  assign at_b   = tick && (tcnt_q == T_B);
  assign at_c   = tick && (tcnt_q == T_C);
  assign at_end = tick && (tcnt_q == T_END);
  assign maj    = (s_a_q & s_b_q) | (s_a_q & rx_s_q) | (s_b_q & rx_s_q);

  always_comb begin
    state_d  = state_q;
    div_d    = (state_q == IDLE || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tcnt_d   = tcnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    s_a_d    = at_a ? rx_s_q : s_a_q;
    s_b_d    = at_b ? rx_s_q : s_b_q;
    pend_d   = pend_q;
    par_en_d = par_en_q;
    even_d   = even_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    fe_d     = fe_q;
    pe_d     = pe_q;

    if (state_q != IDLE && tick) begin
      tcnt_d = at_end ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_en && !rx_s_q) begin
          state_d  = START;
          div_d    = '0;
          tcnt_d   = '0;
          idx_d    = '0;
          pend_d   = 1'b0;
          par_en_d = bus.parity_en;
          even_d   = bus.odd_or_even_parity;
        end
      end
      START: begin
        if (at_c && maj) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_c) begin
          sh_d = {maj, sh_q[data_width-1:1]};
        end
        if (at_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_c) begin
          pend_d = (maj != (^sh_q ^ ~even_q));
        end
        if (at_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Decide at mid-bit so back-to-back frames get the rest of the stop bit as slack.
        if (at_c) begin
          done_d  = 1'b1;
          dout_d  = sh_q;
          pe_d    = pend_q;
          fe_d    = !maj;
          state_d = maj ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tcnt_q   <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      s_a_q    <= 1'b0;
      s_b_q    <= 1'b0;
      pend_q   <= 1'b0;
      par_en_q <= 1'b0;
      even_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tcnt_q   <= tcnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      s_a_q    <= s_a_d;
      s_b_q    <= s_b_d;
      pend_q   <= pend_d;
      par_en_q <= par_en_d;
      even_q   <= even_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.data_out      = dout_q;
  assign bus.framing_error = fe_q;
  assign bus.parity_error  = pe_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed frame table, hand-written corner sequences
// and random frames checked against a line-level reference model.
module tb_uart_rx_oversampled;

  localparam int SYS  = 614_400;
  localparam int BAUD = 9600;
  localparam int W    = 8;
  localparam int OVS  = 16;
  localparam int DIV  = SYS / (BAUD * OVS);
  localparam int BIT  = DIV * OVS;
  localparam int NV   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_oversampled_if #(.data_width(W)) bus ();

  uart_rx_oversampled #(
    .sys_clk   (SYS),
    .baud_rate (BAUD),
    .data_width(W),
    .OVS       (OVS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           pen;
    bit           even;
    bit           flip;
    bit           stop1;
    int           low_bits;
    bit           exp_pe;
    bit           exp_fe;
  } vec_t;

  vec_t           vecs[NV];
  int             checks   = 0;
  int             errors   = 0;
  int             done_cnt = 0;
  bit             prev_done = 1'b0;
  logic [W+1:0]   exp_q[$];
  logic [W+1:0]   last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard: every clk step samples the DUT on the falling edge
  task automatic step();
    logic [W+1:0] e;
    @(negedge clk);
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_not_consecutive", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with data 0x%0h, expected no done at %0t",
                 bus.data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_result{fe,pe,data}",
              32'({bus.framing_error, bus.parity_error, bus.data_out}), 32'(e));
        last_exp = e;
      end
    end
    prev_done = (bus.done === 1'b1);
  endtask

  // line-level reference: parity bit a transmitter puts on the wire
  function automatic bit par_bit(input logic [W-1:0] d, input bit even, input bit flip);
    bit ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    par_bit  = flip ^ (even ? ones_odd : !ones_odd);
  endfunction

  // receiver outcome from the frame as seen on the wire
  function automatic logic [W+1:0] model(input logic [W-1:0] d, input bit pen, input bit even,
                                         input bit flip, input bit stop1);
    int ones;
    bit pe;
    ones  = $countones(d) + int'(par_bit(d, even, flip));
    pe    = pen && ((ones % 2) != (even ? 0 : 1));
    model = {!stop1, pe, d};
  endfunction

  // driver
  task automatic hold(input logic v, input int n, inout int busy_lo, input int d0);
    bus.rx = v;
    for (int c = 0; c < n; c++) begin
      step();
      if (!bus.busy && !bus.done && done_cnt == d0) busy_lo++;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit even, input bit flip,
                            input bit stop1, input int low_bits, input bit mid_toggle,
                            input int n_exp);
    int d0;
    int busy_lo;
    d0      = done_cnt;
    busy_lo = 0;
    bus.parity_en          = pen;
    bus.odd_or_even_parity = even;
    bus.rx = 1'b0;
    repeat (4) step();
    hold(1'b0, BIT - 4, busy_lo, d0);
    if (mid_toggle) begin
      bus.parity_en          = !pen;
      bus.odd_or_even_parity = !even;
      bus.rx_en              = 1'b0;
    end
    for (int i = 0; i < W; i++) hold(d[i], BIT, busy_lo, d0);
    if (pen) hold(par_bit(d, even, flip), BIT, busy_lo, d0);
    hold(stop1, BIT, busy_lo, d0);
    if (!stop1) begin
      hold(1'b0, low_bits * BIT, busy_lo, d0);
      check("busy_in_wait_idle", 32'(bus.busy), 32'(n_exp > 0));
    end
    bus.rx = 1'b1;
    repeat (8) step();
    check("done_count", 32'(done_cnt - d0), 32'(n_exp));
    if (n_exp > 0) check("busy_through_frame", 32'(busy_lo), 32'd0);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    if (mid_toggle) bus.rx_en = 1'b1;
  endtask

  initial begin
    int           d0;
    logic [W-1:0] rd;
    bit           rpen, reven, rflip, rstop;
    int           rlow;

    vecs[0] = '{8'd10,  1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{8'd57,  1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h0A,  1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vecs[3] = '{8'd17,  1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{8'h55,  1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[5] = '{8'hA5,  1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF,  1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[7] = '{8'h00,  1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0};

    bus.rx                 = 1'b1;
    bus.rx_en              = 1'b1;
    bus.parity_en          = 1'b0;
    bus.odd_or_even_parity = 1'b1;

    // reset state
    repeat (3) step();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_fe", 32'(bus.framing_error), 32'd0);
    check("reset_pe", 32'(bus.parity_error), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b1;
    repeat (4) step();

    // directed table
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back({vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].data});
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].even, vecs[i].flip, vecs[i].stop1,
                 vecs[i].low_bits, 1'b0, 1);
    end

    // parity settings and rx_en changed mid-frame: frame uses the values seen at start
    exp_q.push_back(model(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1));
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1);

    // rx_en low: frame ignored
    bus.rx_en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
    bus.rx_en = 1'b1;
    repeat (4) step();

    // 3-tick low glitch aborts in START
    d0 = done_cnt;
    bus.rx = 1'b0;
    repeat (3 * DIV) step();
    check("glitch_busy_rises", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    repeat (2 * BIT) step();
    check("glitch_busy_falls", 32'(bus.busy), 32'd0);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_outputs_held",
          32'({bus.framing_error, bus.parity_error, bus.data_out}), 32'(last_exp));

    // random frames against the reference model
    for (int n = 0; n < 20; n++) begin
      rd    = W'($urandom_range(0, (1 << W) - 1));
      rpen  = 1'($urandom_range(0, 1));
      reven = 1'($urandom_range(0, 1));
      rflip = rpen && ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      rlow  = rstop ? 0 : int'($urandom_range(1, 2));
      exp_q.push_back(model(rd, rpen, reven, rflip, rstop));
      send_frame(rd, rpen, reven, rflip, rstop, rlow, 1'b0, 1);
    end

    // reset in the middle of a 0xFF frame
    d0 = done_cnt;
    bus.parity_en = 1'b0;
    bus.rx = 1'b0;
    repeat (BIT) step();
    bus.rx = 1'b1;
    repeat (3 * BIT) step();
    rst = 1'b0;
    repeat (2) step();
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_data_out", 32'(bus.data_out), 32'd0);
    check("midreset_errors", 32'({bus.framing_error, bus.parity_error}), 32'd0);
    rst = 1'b1;
    repeat (BIT * 8) step();
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1);
    check("after_reset_data_out", 32'(bus.data_out), 32'h3C);

    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
